// File: rtl/keccak_round_sequencer.sv
// Round sequencer for the Keccak-f[1600] datapath: accepts a state, steps the round
// index in groups of UNROLL, then holds the result under a valid/ready handshake.
// Build option KECCAK_PERM_COUNT_EN adds a saturating completed-permutation counter.
module keccak_round_sequencer #(
    parameter int NUM_ROUNDS = 24,
    parameter int UNROLL     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        abort,
    output logic        load_en,
    output logic        round_en,
    output logic [4:0]  round_idx,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy
`ifdef KECCAK_PERM_COUNT_EN
    ,
    output logic [31:0] perm_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ROUND = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    localparam logic [4:0] IDX_STEP = 5'(UNROLL);
    localparam logic [4:0] IDX_LAST = 5'(NUM_ROUNDS - UNROLL);

    state_e     state_q;
    state_e     state_d;
    logic [4:0] idx_q;
    logic [4:0] idx_d;
    logic       accept_s;
    logic       in_ready_s;

    // State and round-index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Accept handshake: abort and reset both veto a load, even when the result is taken.
    always_comb begin
        in_ready_s = 1'b0;
        if (rst) begin
            in_ready_s = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE:  in_ready_s = 1'b1;
                ST_DONE:  in_ready_s = out_ready & ~abort;
                default:  in_ready_s = 1'b0;
            endcase
        end
        accept_s = in_ready_s & in_valid;
    end

    // Next-state and round-index logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                idx_d = 5'd0;
                if (accept_s) begin
                    state_d = ST_ROUND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ROUND: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    idx_d   = 5'd0;
                end else if (idx_q == IDX_LAST) begin
                    state_d = ST_DONE;
                    idx_d   = 5'd0;
                end else begin
                    state_d = ST_ROUND;
                    idx_d   = idx_q + IDX_STEP;
                end
            end
            ST_DONE: begin
                idx_d = 5'd0;
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (out_ready) begin
                    // Back-to-back: result consumed and next state loaded in one cycle.
                    if (accept_s) begin
                        state_d = ST_ROUND;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 5'd0;
            end
        endcase
    end

    assign in_ready  = in_ready_s;
    assign load_en   = accept_s;
    assign round_en  = (state_q == ST_ROUND);
    assign round_idx = idx_q;
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);

`ifdef KECCAK_PERM_COUNT_EN
    logic [31:0] perm_cnt_q;
    logic [31:0] perm_cnt_d;
    logic        consume_s;

    // A result only counts when the consumer takes it and no abort cancels it.
    always_comb begin
        consume_s  = (state_q == ST_DONE) & out_ready & ~abort;
        perm_cnt_d = perm_cnt_q;
        if (consume_s && (perm_cnt_q != 32'hFFFF_FFFF)) begin
            perm_cnt_d = perm_cnt_q + 32'd1;
        end else begin
            perm_cnt_d = perm_cnt_q;
        end
    end

    // Counter register; cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            perm_cnt_q <= 32'd0;
        end else begin
            perm_cnt_q <= perm_cnt_d;
        end
    end

    assign perm_count = perm_cnt_q;
`endif

endmodule

// File: tb/tb_keccak_round_sequencer.sv
// Bench for keccak_round_sequencer: directed steps then random traffic on an UNROLL=1
// and an UNROLL=4 instance, every cycle checked against a phase-counting reference model.
module tb_keccak_round_sequencer;

    localparam int U0 = 1;
    localparam int U1 = 4;
    localparam int NR = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst[2];
    logic       in_valid[2];
    logic       abort[2];
    logic       out_ready[2];
    logic       in_ready[2];
    logic       load_en[2];
    logic       round_en[2];
    logic [4:0] round_idx[2];
    logic       out_valid[2];
    logic       busy[2];
`ifdef KECCAK_PERM_COUNT_EN
    logic [31:0] perm_count[2];
`endif

    keccak_round_sequencer #(.NUM_ROUNDS(NR), .UNROLL(U0)) dut0 (
        .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .abort(abort[0]), .load_en(load_en[0]), .round_en(round_en[0]),
        .round_idx(round_idx[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .busy(busy[0])
`ifdef KECCAK_PERM_COUNT_EN
        , .perm_count(perm_count[0])
`endif
    );

    keccak_round_sequencer #(.NUM_ROUNDS(NR), .UNROLL(U1)) dut1 (
        .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .abort(abort[1]), .load_en(load_en[1]), .round_en(round_en[1]),
        .round_idx(round_idx[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .busy(busy[1])
`ifdef KECCAK_PERM_COUNT_EN
        , .perm_count(perm_count[1])
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: phase -1 = idle, 0..G-1 = round group being applied, G = result held.
    int          m_ph[2];
    logic [31:0] m_cnt[2];

    function automatic int unr(int k);
        return (k == 0) ? U0 : U1;
    endfunction

    task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            int  g;
            bit  re;
            bit  ir;
            g  = NR / unr(k);
            re = (m_ph[k] >= 0) && (m_ph[k] < g);
            ir = !rst[k] && ((m_ph[k] == -1) || ((m_ph[k] == g) && out_ready[k] && !abort[k]));
            chk("round_en",  k, 32'(round_en[k]),  32'(re));
            chk("round_idx", k, 32'(round_idx[k]), re ? 32'(m_ph[k] * unr(k)) : 32'd0);
            chk("out_valid", k, 32'(out_valid[k]), 32'(m_ph[k] == g));
            chk("busy",      k, 32'(busy[k]),      32'(m_ph[k] != -1));
            chk("in_ready",  k, 32'(in_ready[k]),  32'(ir));
            chk("load_en",   k, 32'(load_en[k]),   32'(ir && in_valid[k]));
`ifdef KECCAK_PERM_COUNT_EN
            chk("perm_count", k, perm_count[k], m_cnt[k]);
`endif
        end
    endtask

    task automatic update_model();
        for (int k = 0; k < 2; k++) begin
            int g;
            g = NR / unr(k);
            if (rst[k]) begin
                m_ph[k]  = -1;
                m_cnt[k] = 32'd0;
            end else if (abort[k] && (m_ph[k] != -1)) begin
                m_ph[k] = -1;
            end else if (m_ph[k] == -1) begin
                if (in_valid[k]) m_ph[k] = 0;
            end else if (m_ph[k] < g) begin
                m_ph[k] = m_ph[k] + 1;
            end else if (out_ready[k]) begin
                if (m_cnt[k] != 32'hFFFF_FFFF) m_cnt[k] = m_cnt[k] + 32'd1;
                m_ph[k] = in_valid[k] ? 0 : -1;
            end
        end
    endtask

    task automatic tick();
        #1;
        check_all();
        @(posedge clk);
        update_model();
        @(negedge clk);
    endtask

    task automatic clear_in();
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b0; in_valid[k] = 1'b0; abort[k] = 1'b0; out_ready[k] = 1'b0;
        end
    endtask

    task automatic run_one(int k);
        in_valid[k] = 1'b1;
        tick();
        in_valid[k] = 1'b0;
        repeat (NR / unr(k)) tick();
        out_ready[k] = 1'b1;
        tick();
        out_ready[k] = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; in_valid[k] = 1'b0; abort[k] = 1'b0; out_ready[k] = 1'b0;
            m_ph[k] = -1; m_cnt[k] = 32'd0;
        end
        @(negedge clk);
        @(negedge clk);
        tick();
        clear_in();
        tick();

        // UNROLL=1 full permutation, one cycle of backpressure in DONE.
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        repeat (NR) tick();
        chk("latency_ov", 0, 32'(out_valid[0]), 32'd1);
        tick();
        out_ready[0] = 1'b1;
        tick();
        out_ready[0] = 1'b0;
        tick();

        // UNROLL=4: six round groups.
        run_one(1);
        tick();

        // Back-to-back accept while the result is consumed.
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        repeat (NR) tick();
        repeat (3) tick();
        in_valid[0] = 1'b1; out_ready[0] = 1'b1;
        tick();
        clear_in();
        repeat (NR) tick();
        out_ready[0] = 1'b1;
        tick();
        clear_in();
        tick();

        // Abort at round_idx 10, then a fresh full request.
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        repeat (10) tick();
        abort[0] = 1'b1; in_valid[0] = 1'b1;
        tick();
        clear_in();
        repeat (3) tick();
        run_one(0);
        tick();

        // Reset at round_idx 5 together with in_valid.
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        repeat (5) tick();
        rst[0] = 1'b1; in_valid[0] = 1'b1;
        tick();
        clear_in();
        tick();

        // Three completions plus one aborted in DONE with out_ready high.
        repeat (3) run_one(0);
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        repeat (NR) tick();
        abort[0] = 1'b1; out_ready[0] = 1'b1;
        tick();
        clear_in();
        tick();
`ifdef KECCAK_PERM_COUNT_EN
        chk("count_3", 0, perm_count[0], 32'd3);
        force dut0.perm_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut0.perm_cnt_q;
        m_cnt[0] = 32'hFFFF_FFFF;
        run_one(0);
        tick();
        chk("count_sat", 0, perm_count[0], 32'hFFFF_FFFF);
`endif

        // Random traffic on both instances.
        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < 2; k++) begin
                rst[k]       = ($urandom_range(99) == 0);
                abort[k]     = ($urandom_range(29) == 0);
                in_valid[k]  = ($urandom_range(2) != 0);
                out_ready[k] = ($urandom_range(1) != 0);
            end
            tick();
        end
        clear_in();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
